// File: rtl/rgb_ycbcr_seg_stat_if.sv
// Pixel stream, window programming and per-frame statistics bundle for rgb_ycbcr_seg_stat.
// master drives the capture side and window; slave (the stage) drives the post side and stats.
interface rgb_ycbcr_seg_stat_if #(
    parameter int X_W   = 10,
    parameter int Y_W   = 10,
    parameter int CNT_W = 20
);
    logic [4:0]       cmos_R;
    logic [5:0]       cmos_G;
    logic [4:0]       cmos_B;
    logic             per_frame_clken;
    logic             per_frame_vsync;
    logic             per_frame_href;
    logic [1:0]       mode;
    logic [7:0]       cb_lo;
    logic [7:0]       cb_hi;
    logic [7:0]       cr_lo;
    logic [7:0]       cr_hi;
    logic             post_frame_clken;
    logic             post_frame_vsync;
    logic             post_frame_href;
    logic [7:0]       img_Y;
    logic [7:0]       img_Cb;
    logic [7:0]       img_Cr;
    logic             mask;
    logic [15:0]      pix_out;
    logic             stat_valid;
    logic [CNT_W-1:0] stat_count;
    logic [X_W-1:0]   stat_xmin;
    logic [X_W-1:0]   stat_xmax;
    logic [Y_W-1:0]   stat_ymin;
    logic [Y_W-1:0]   stat_ymax;

    modport master (
        output cmos_R, cmos_G, cmos_B, per_frame_clken, per_frame_vsync, per_frame_href,
               mode, cb_lo, cb_hi, cr_lo, cr_hi,
        input  post_frame_clken, post_frame_vsync, post_frame_href, img_Y, img_Cb, img_Cr,
               mask, pix_out, stat_valid, stat_count, stat_xmin, stat_xmax, stat_ymin, stat_ymax
    );

    modport slave (
        input  cmos_R, cmos_G, cmos_B, per_frame_clken, per_frame_vsync, per_frame_href,
               mode, cb_lo, cb_hi, cr_lo, cr_hi,
        output post_frame_clken, post_frame_vsync, post_frame_href, img_Y, img_Cb, img_Cr,
               mask, pix_out, stat_valid, stat_count, stat_xmin, stat_xmax, stat_ymin, stat_ymax
    );
endinterface

// File: rtl/rgb_ycbcr_seg_stat.sv
// RGB565 -> BT.601 YCbCr colour segmentation with a frame-latched Cb/Cr window,
// four output modes and per-frame match count / bounding box. Latency 4 clk.
module rgb_ycbcr_seg_stat #(
    parameter int X_W   = 10,
    parameter int Y_W   = 10,
    parameter int CNT_W = 20
) (
    input logic                clk,
    input logic                rst_n,
    rgb_ycbcr_seg_stat_if.slave bus
);
    typedef enum logic [1:0] {MODE_GRAY, MODE_MASK, MODE_OVERLAY, MODE_PASS} mode_e;

    localparam logic [X_W-1:0]   X_MAX   = '1;
    localparam logic [Y_W-1:0]   Y_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic        vsync_in_d;
    logic        vsync_in_rise;
    mode_e       mode_s;
    logic [7:0]  cb_lo_s, cb_hi_s, cr_lo_s, cr_hi_s;
    logic [7:0]  r8, g8, b8;
    logic [15:0] p_yr, p_yg, p_yb, p_cbr, p_cbg, p_cbb, p_crr, p_crg, p_crb;
    logic [15:0] y_sum, cb_sum, cr_sum;
    logic [7:0]  y3, cb3, cr3;
    logic [15:0] pix1, pix2, pix3;
    logic [3:0]  clken_sr, href_sr, vsync_sr;
    logic        hit;
    logic [15:0] pix_sel;
    logic [7:0]  y_r, cb_r, cr_r;
    logic        mask_r;
    logic [15:0] pix_r;

    assign vsync_in_rise = bus.per_frame_vsync & ~vsync_in_d;
    assign r8 = {bus.cmos_R, bus.cmos_R[4:2]};
    assign g8 = {bus.cmos_G, bus.cmos_G[5:4]};
    assign b8 = {bus.cmos_B, bus.cmos_B[4:2]};

    // Window and mode are sampled once per frame so a mid-frame rewrite cannot split a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_in_d <= 1'b0;
            mode_s     <= MODE_GRAY;
            cb_lo_s    <= '0;
            cb_hi_s    <= '0;
            cr_lo_s    <= '0;
            cr_hi_s    <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values regardless of order.
            vsync_in_d <= bus.per_frame_vsync;
            if (vsync_in_rise) begin
                mode_s  <= mode_e'(bus.mode);
                cb_lo_s <= bus.cb_lo;
                cb_hi_s <= bus.cb_hi;
                cr_lo_s <= bus.cr_lo;
                cr_hi_s <= bus.cr_hi;
            end
        end
    end

    // NOTE: datapath registers are reset too, so nothing stale reaches the outputs after rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {p_yr, p_yg, p_yb, p_cbr, p_cbg, p_cbb, p_crr, p_crg, p_crb} <= '0;
            {y_sum, cb_sum, cr_sum} <= '0;
            {y3, cb3, cr3}          <= '0;
            {pix1, pix2, pix3}      <= '0;
            {clken_sr, href_sr, vsync_sr} <= '0;
            {y_r, cb_r, cr_r, mask_r, pix_r} <= '0;
        end else begin
            p_yr  <= 16'(r8) * 16'd77;
            p_yg  <= 16'(g8) * 16'd150;
            p_yb  <= 16'(b8) * 16'd29;
            p_cbr <= 16'(r8) * 16'd43;
            p_cbg <= 16'(g8) * 16'd85;
            p_cbb <= 16'(b8) * 16'd128;
            p_crr <= 16'(r8) * 16'd128;
            p_crg <= 16'(g8) * 16'd107;
            p_crb <= 16'(b8) * 16'd21;
            y_sum  <= p_yr + p_yg + p_yb;
            cb_sum <= p_cbb - p_cbr - p_cbg + 16'd32768;
            cr_sum <= p_crr - p_crg - p_crb + 16'd32768;
            y3  <= y_sum[15:8];
            cb3 <= cb_sum[15:8];
            cr3 <= cr_sum[15:8];
            pix1 <= {bus.cmos_R, bus.cmos_G, bus.cmos_B};
            pix2 <= pix1;
            pix3 <= pix2;
            clken_sr <= {clken_sr[2:0], bus.per_frame_clken};
            href_sr  <= {href_sr[2:0],  bus.per_frame_href};
            vsync_sr <= {vsync_sr[2:0], bus.per_frame_vsync};
            if (href_sr[2]) begin
                y_r    <= y3;
                cb_r   <= cb3;
                cr_r   <= cr3;
                mask_r <= hit;
                pix_r  <= pix_sel;
            end else begin
                {y_r, cb_r, cr_r, mask_r, pix_r} <= '0;
            end
        end
    end

    // An inverted window (lo > hi) can never satisfy both bounds, so it masks everything.
    assign hit = (cb3 >= cb_lo_s) && (cb3 <= cb_hi_s) && (cr3 >= cr_lo_s) && (cr3 <= cr_hi_s);

    always_comb begin
        // NOTE: default first so no path leaves pix_sel unassigned (no latch).
        pix_sel = pix3;
        case (mode_s)
            MODE_GRAY:    pix_sel = {y3[7:3], y3[7:2], y3[7:3]};
            MODE_MASK:    pix_sel = hit ? 16'hFFFF : 16'h0000;
            MODE_OVERLAY: pix_sel = hit ? 16'hF800 : pix3;
            default:      pix_sel = pix3;
        endcase
    end

    // Statistics run on the delayed side so coordinates line up with the mask they count.
    logic             post_href_d, post_vsync_d, post_vs_rise, href_fall, pix_hit;
    logic [X_W-1:0]   x_cnt, acc_xmin, acc_xmax, st_xmin, st_xmax;
    logic [Y_W-1:0]   y_cnt, acc_ymin, acc_ymax, st_ymin, st_ymax;
    logic [CNT_W-1:0] acc_count, st_count;
    logic             seen, any_match, st_valid;

    assign post_vs_rise = vsync_sr[3] & ~post_vsync_d;
    assign href_fall    = ~href_sr[3] & post_href_d;
    assign pix_hit      = clken_sr[3] & href_sr[3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {post_href_d, post_vsync_d, seen, any_match, st_valid} <= '0;
            {x_cnt, acc_xmin, acc_xmax, st_xmin, st_xmax} <= '0;
            {y_cnt, acc_ymin, acc_ymax, st_ymin, st_ymax} <= '0;
            {acc_count, st_count} <= '0;
        end else begin
            post_href_d  <= href_sr[3];
            post_vsync_d <= vsync_sr[3];
            st_valid     <= 1'b0;
            if (post_vs_rise) begin
                x_cnt <= '0;
                y_cnt <= '0;
                if (seen) begin
                    st_count <= acc_count;
                    st_xmin  <= acc_xmin;
                    st_xmax  <= acc_xmax;
                    st_ymin  <= acc_ymin;
                    st_ymax  <= acc_ymax;
                    st_valid <= 1'b1;
                end
                {seen, any_match, acc_count} <= '0;
                {acc_xmin, acc_xmax, acc_ymin, acc_ymax} <= '0;
            end else begin
                if (pix_hit) begin
                    seen <= 1'b1;
                    if (x_cnt != X_MAX) x_cnt <= x_cnt + 1'b1;
                    if (mask_r) begin
                        any_match <= 1'b1;
                        if (acc_count != CNT_MAX) acc_count <= acc_count + 1'b1;
                        if (!any_match || x_cnt < acc_xmin) acc_xmin <= x_cnt;
                        if (!any_match || x_cnt > acc_xmax) acc_xmax <= x_cnt;
                        if (!any_match || y_cnt < acc_ymin) acc_ymin <= y_cnt;
                        if (!any_match || y_cnt > acc_ymax) acc_ymax <= y_cnt;
                    end
                end
                if (href_fall) begin
                    x_cnt <= '0;
                    if (y_cnt != Y_MAX) y_cnt <= y_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.post_frame_clken = clken_sr[3];
    assign bus.post_frame_href  = href_sr[3];
    assign bus.post_frame_vsync = vsync_sr[3];
    assign bus.img_Y      = y_r;
    assign bus.img_Cb     = cb_r;
    assign bus.img_Cr     = cr_r;
    assign bus.mask       = mask_r;
    assign bus.pix_out    = pix_r;
    assign bus.stat_valid = st_valid;
    assign bus.stat_count = st_count;
    assign bus.stat_xmin  = st_xmin;
    assign bus.stat_xmax  = st_xmax;
    assign bus.stat_ymin  = st_ymin;
    assign bus.stat_ymax  = st_ymax;
endmodule

// File: tb/tb_rgb_ycbcr_seg_stat.sv
// Scoreboard bench for rgb_ycbcr_seg_stat: stimulus pushes expected pixels and frame stats,
// a negedge monitor pops and compares whenever the DUT presents a pixel or a stat pulse.
module tb_rgb_ycbcr_seg_stat;
    typedef struct {
        int unsigned cyc;
        logic [7:0]  y, cb, cr;
        logic        m;
        logic [15:0] pix;
    } pix_exp_t;

    typedef struct {
        int unsigned cnt, xmin, xmax, ymin, ymax;
    } stat_exp_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    int unsigned cyc   = 0;
    int          n_vec = 0;
    int          n_err = 0;
    pix_exp_t    pix_q[$];
    stat_exp_t   stat_q[$];
    int          mx_q[$];
    int          my_q[$];
    bit          f_seen = 1'b0;
    logic [1:0]  f_mode = '0;
    logic [7:0]  f_cbl = '0, f_cbh = '0, f_crl = '0, f_crh = '0;

    rgb_ycbcr_seg_stat_if #(.X_W(10), .Y_W(10), .CNT_W(20)) bus ();

    rgb_ycbcr_seg_stat #(.X_W(10), .Y_W(10), .CNT_W(20)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: BT.601 integer formulas on the 888-expanded pixel, window held for the frame.
    function automatic pix_exp_t model(input logic [15:0] p);
        pix_exp_t e;
        int r, g, b, yy, cb, cr;
        r  = int'(p[15:11]) * 8 + int'(p[15:11]) / 4;
        g  = int'(p[10:5]) * 4 + int'(p[10:5]) / 16;
        b  = int'(p[4:0]) * 8 + int'(p[4:0]) / 4;
        yy = ((77 * r + 150 * g + 29 * b) % 65536) / 256;
        cb = (((128 * b - 43 * r - 85 * g + 32768) % 65536 + 65536) % 65536) / 256;
        cr = (((128 * r - 107 * g - 21 * b + 32768) % 65536 + 65536) % 65536) / 256;
        e.cyc = 0;
        e.y   = 8'(yy);
        e.cb  = 8'(cb);
        e.cr  = 8'(cr);
        e.m   = (cb >= int'(f_cbl)) && (cb <= int'(f_cbh)) && (cr >= int'(f_crl)) && (cr <= int'(f_crh));
        case (f_mode)
            2'd0:    e.pix = {e.y[7:3], e.y[7:2], e.y[7:3]};
            2'd1:    e.pix = e.m ? 16'hFFFF : 16'h0000;
            2'd2:    e.pix = e.m ? 16'hF800 : p;
            default: e.pix = p;
        endcase
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.per_frame_clken = 1'b0;
        bus.per_frame_href  = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send_pixel(input logic [15:0] p, input int x, input int y, input pix_exp_t e);
        pix_exp_t ee;
        ee = e;
        bus.cmos_R = p[15:11];
        bus.cmos_G = p[10:5];
        bus.cmos_B = p[4:0];
        bus.per_frame_clken = 1'b1;
        bus.per_frame_href  = 1'b1;
        ee.cyc = cyc + 4;
        pix_q.push_back(ee);
        f_seen = 1'b1;
        if (ee.m) begin
            mx_q.push_back(x);
            my_q.push_back(y);
        end
        tick();
    endtask

    task automatic set_win(input logic [1:0] md, input logic [7:0] cbl, input logic [7:0] cbh,
                           input logic [7:0] crl, input logic [7:0] crh);
        bus.mode  = md;
        bus.cb_lo = cbl;
        bus.cb_hi = cbh;
        bus.cr_lo = crl;
        bus.cr_hi = crh;
    endtask

    task automatic set_win_rand();
        int lb, lr;
        lb = $urandom_range(40, 170);
        lr = $urandom_range(40, 170);
        set_win(2'($urandom_range(0, 3)), 8'(lb), 8'((lb + $urandom_range(30, 120)) > 255 ? 255 : lb + $urandom_range(30, 120)),
                8'(lr), 8'((lr + 90) > 255 ? 255 : lr + 90));
    endtask

    // Ends the current frame: pushes its expected stats (if any pixel was seen) and latches the next window.
    task automatic frame_end(input bit lit, input stat_exp_t ls);
        stat_exp_t s;
        idle(6);
        if (f_seen) begin
            s = '{0, 0, 0, 0, 0};
            if (lit) s = ls;
            else if (mx_q.size() > 0) begin
                s.cnt  = mx_q.size();
                s.xmin = mx_q.min()[0];
                s.xmax = mx_q.max()[0];
                s.ymin = my_q.min()[0];
                s.ymax = my_q.max()[0];
            end
            stat_q.push_back(s);
        end
        bus.per_frame_vsync = 1'b1;
        f_mode = bus.mode;
        f_cbl  = bus.cb_lo;
        f_cbh  = bus.cb_hi;
        f_crl  = bus.cr_lo;
        f_crh  = bus.cr_hi;
        tick();
        tick();
        bus.per_frame_vsync = 1'b0;
        f_seen = 1'b0;
        mx_q.delete();
        my_q.delete();
        idle(3);
    endtask

    // kind 0: random pixels; kind 1: black frame with pure blue at (1,2) and (3,1).
    task automatic frame(input int w, input int h, input int kind);
        logic [15:0] p;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                if ($urandom_range(0, 3) == 0) begin
                    bus.per_frame_clken = 1'b0;
                    bus.per_frame_href  = 1'b1;
                    bus.cmos_R = 5'($urandom);
                    tick();
                end
                if (kind == 1) p = ((x == 1 && y == 2) || (x == 3 && y == 1)) ? 16'h001F : 16'h0000;
                else p = 16'($urandom);
                send_pixel(p, x, y, model(p));
            end
            idle(2);
            if (y == 0) set_win(2'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        end
    endtask

    always @(negedge clk) begin
        pix_exp_t e;
        stat_exp_t s;
        if (rst_n) begin
            if (bus.post_frame_clken && bus.post_frame_href) begin
                if (pix_q.size() == 0) check("pix_unexpected", 1, 0);
                else begin
                    e = pix_q.pop_front();
                    check("latency", cyc, e.cyc);
                    check("img_Y", 32'(bus.img_Y), 32'(e.y));
                    check("img_Cb", 32'(bus.img_Cb), 32'(e.cb));
                    check("img_Cr", 32'(bus.img_Cr), 32'(e.cr));
                    check("mask", 32'(bus.mask), 32'(e.m));
                    check("pix_out", 32'(bus.pix_out), 32'(e.pix));
                end
            end else if (!bus.post_frame_href) begin
                check("idle_ycc", {8'h0, bus.img_Y, bus.img_Cb, bus.img_Cr}, 0);
                check("idle_pix", {15'h0, bus.mask, bus.pix_out}, 0);
            end
            if (bus.stat_valid) begin
                if (stat_q.size() == 0) check("stat_unexpected", 1, 0);
                else begin
                    s = stat_q.pop_front();
                    check("stat_count", 32'(bus.stat_count), s.cnt);
                    check("stat_xmin", 32'(bus.stat_xmin), s.xmin);
                    check("stat_xmax", 32'(bus.stat_xmax), s.xmax);
                    check("stat_ymin", 32'(bus.stat_ymin), s.ymin);
                    check("stat_ymax", 32'(bus.stat_ymax), s.ymax);
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_post"}, {bus.post_frame_clken, bus.post_frame_href, bus.post_frame_vsync, bus.stat_valid}, 0);
        check({tag, "_ycc"}, {8'h0, bus.img_Y, bus.img_Cb, bus.img_Cr}, 0);
        check({tag, "_pix"}, {15'h0, bus.mask, bus.pix_out}, 0);
        check({tag, "_cnt"}, 32'(bus.stat_count), 0);
        check({tag, "_bbox"}, {6'h0, bus.stat_xmin, bus.stat_xmax, bus.stat_ymin[9:4]}, 0);
        check({tag, "_ylo"}, {bus.stat_ymin[3:0], bus.stat_ymax}, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1);
    end

    initial begin
        pix_exp_t e;
        bus.cmos_R = '0;
        bus.cmos_G = '0;
        bus.cmos_B = '0;
        bus.per_frame_clken = 1'b0;
        bus.per_frame_href  = 1'b0;
        bus.per_frame_vsync = 1'b0;
        set_win(2'd0, 8'd0, 8'd0, 8'd0, 8'd0);
        repeat (3) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // First vsync after reset: nothing seen yet, so no stat pulse is expected.
        set_win(2'd0, 8'd0, 8'd255, 8'd0, 8'd255);
        frame_end(1'b0, '{0, 0, 0, 0, 0});

        e = '{0, 8'd76, 8'd85, 8'd255, 1'b1, 16'h4A69};
        send_pixel(16'hF800, 0, 0, e);
        idle(2);

        set_win(2'd1, 8'd179, 8'd255, 8'd97, 8'd108);
        frame_end(1'b0, '{0, 0, 0, 0, 0});
        frame(4, 4, 1);

        set_win(2'd2, 8'd200, 8'd100, 8'd0, 8'd255);
        frame_end(1'b1, '{2, 1, 3, 1, 2});
        frame(5, 3, 0);

        set_win_rand();
        frame_end(1'b1, '{0, 0, 0, 0, 0});
        for (int f = 0; f < 12; f++) begin
            frame($urandom_range(3, 8), $urandom_range(2, 5), 0);
            set_win_rand();
            frame_end(1'b0, '{0, 0, 0, 0, 0});
        end

        // Reset in the middle of a line: partial frame is discarded.
        for (int x = 0; x < 3; x++) send_pixel(16'($urandom), x, 0, model(16'($urandom)));
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        pix_q.delete();
        mx_q.delete();
        my_q.delete();
        f_seen = 1'b0;
        idle(3);
        rst_n = 1'b1;
        tick();
        set_win_rand();
        frame_end(1'b0, '{0, 0, 0, 0, 0});
        frame(6, 4, 0);
        set_win_rand();
        frame_end(1'b0, '{0, 0, 0, 0, 0});

        idle(20);
        check("pix_q_drained", pix_q.size(), 0);
        check("stat_q_drained", stat_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
